// File: rtl/mem_rep_pkg.sv
// Shared types and constants for the M-stage string-op address engine.
// State encoding, REP mode codes, operand size codes and step magnitudes.
package mem_rep_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] REP_MODE_REP   = 2'b00;
  localparam logic [1:0] REP_MODE_REPE  = 2'b01;
  localparam logic [1:0] REP_MODE_REPNE = 2'b10;

  localparam logic [1:0] OPSIZE_B = 2'b00;
  localparam logic [1:0] OPSIZE_W = 2'b01;
  localparam logic [1:0] OPSIZE_D = 2'b10;
  localparam logic [1:0] OPSIZE_Q = 2'b11;

  localparam logic [3:0] STEP_B = 4'd1;
  localparam logic [3:0] STEP_W = 4'd2;
  localparam logic [3:0] STEP_D = 4'd4;
  localparam logic [3:0] STEP_Q = 4'd8;

endpackage

// File: rtl/mem_rep_step_gen.sv
// Per-iteration address step: size from opsize, negated when the
// direction flag is set. One instance feeds every channel adder.
module mem_rep_step_gen
  import mem_rep_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [1:0]    opsize,
  input  logic          dflag,
  output logic [AW-1:0] step
);

  logic [3:0]    mag4;
  logic [AW-1:0] mag;

  always_comb begin
    mag4 = STEP_B;
    unique case (opsize)
      OPSIZE_B: mag4 = STEP_B;
      OPSIZE_W: mag4 = STEP_W;
      OPSIZE_D: mag4 = STEP_D;
      OPSIZE_Q: mag4 = STEP_Q;
      default:  mag4 = STEP_B;
    endcase
    mag  = {{(AW-4){1'b0}}, mag4};
    step = dflag ? (~mag + 1'b1) : mag;
  end

endmodule

// File: rtl/mem_rep_agu.sv
// REP/REPE/REPNE address and count engine for the M stage.
// IDLE bypasses the latch inputs; RUN replays from internal registers.
module mem_rep_agu
  import mem_rep_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int AW     = 32,
  parameter int CW     = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 valid_in,
  input  logic                 is_rep_in,
  input  logic [1:0]           rep_mode_in,
  input  logic [1:0]           opsize_in,
  input  logic                 dflag_set,
  input  logic                 dflag_clr,
  input  logic [NUM_CH*AW-1:0] addr_in,
  input  logic [CW-1:0]        cnt_in,
  input  logic                 hold_in,
  input  logic                 zf_valid_in,
  input  logic                 zf_in,
  output logic [NUM_CH*AW-1:0] addr_out,
  output logic [CW-1:0]        cnt_out,
  output logic                 iter_valid,
  output logic                 rep_stall,
  output logic                 rep_done,
  output logic                 busy
);

  state_e        state_q, state_d;
  logic          dflag_q, dflag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    op_q, op_d;
  logic          load;
  logic          term;
  logic          in_run;
  logic [1:0]    mode_eff;
  logic [1:0]    op_eff;
  logic [AW-1:0] step;

  assign in_run   = (state_q == RUN);
  assign mode_eff = in_run ? mode_q : rep_mode_in;
  assign op_eff   = in_run ? op_q : opsize_in;
  assign cnt_out  = in_run ? cnt_q : cnt_in;
  assign busy     = in_run;

  assign term = zf_valid_in &
    (((mode_eff == REP_MODE_REPE) & ~zf_in) |
     ((mode_eff == REP_MODE_REPNE) & zf_in));

  mem_rep_step_gen #(.AW(AW)) u_step (
    .opsize (op_eff),
    .dflag  (dflag_q),
    .step   (step)
  );

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [AW-1:0] base;
    logic [AW-1:0] addr_d, addr_q;

    assign base = in_run ? addr_q : addr_in[ch*AW +: AW];
    assign addr_out[ch*AW +: AW] = base;

    always_comb begin
      addr_d = addr_q;
      if (load) addr_d = base + step;
    end

    always_ff @(posedge clk) begin
      if (clr) addr_q <= '0;
      else     addr_q <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    op_d       = op_q;
    load       = 1'b0;
    iter_valid = 1'b0;
    rep_stall  = 1'b0;
    rep_done   = 1'b0;
    dflag_d    = dflag_q;
    if (dflag_set) dflag_d = 1'b1;
    if (dflag_clr) dflag_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_in && !is_rep_in) begin
          iter_valid = 1'b1;
        end else if (valid_in && cnt_in == '0) begin
          rep_done = 1'b1;
        end else if (valid_in) begin
          iter_valid = 1'b1;
          if (hold_in) begin
            rep_stall = (cnt_in != CW'(1));
          end else begin
            load   = 1'b1;
            cnt_d  = cnt_in - CW'(1);
            mode_d = rep_mode_in;
            op_d   = opsize_in;
            if (term || cnt_in == CW'(1)) begin
              rep_done = 1'b1;
            end else begin
              rep_stall = 1'b1;
              state_d   = RUN;
            end
          end
        end
      end
      RUN: begin
        iter_valid = 1'b1;
        if (hold_in) begin
          rep_stall = 1'b1;
        end else begin
          load  = 1'b1;
          cnt_d = cnt_q - CW'(1);
          // ZF abort wins over the count test
          if (term || cnt_q == CW'(1)) begin
            rep_done = 1'b1;
            state_d  = IDLE;
          end else begin
            rep_stall = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      dflag_q <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      dflag_q <= dflag_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
    end
  end

endmodule
